risc_core_mc: RTL and testbench
===============================

Name: risc_core_mc

Overview:
- Parametrised multi-cycle successor to the single-path accumulator datapath.
- Contains a 4-entry general register file, PC, IR, ALU with a full-width multiplier, and a double-width result register.
- Adds a fetch handshake that tolerates wait states, conditional/unconditional branches, halt, illegal-opcode detection and a retired-instruction counter.
- Sits between an external instruction memory (req/valid) and the system result sink.

Parameters:
- DW, 16, data/register width in bits; legal range 8..32.
- PCW, 16, PC / instruction address width in bits; word-addressed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high only in FETCH, forced 0 while rst=1.
- imem_addr  output  PCW  fetch address; equals pc.
- imem_rdata  input  16  instruction word; sampled only when imem_req & imem_valid.
- imem_valid  input  1  instruction valid; ignored when imem_req=0.
- result  output  2*DW  result register (regC successor).
- result_valid  output  1  one-cycle pulse on the cycle after result is written.
- halted  output  1  high while in HALT state.
- illegal  output  1  sticky; set by an undefined opcode.
- retired  output  32  count of retired instructions; wraps at 2^32.
- pc  output  PCW  current PC.

Behaviour:
- Encoding: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8.
  - simm = imm8 sign-extended to DW.
  - All register arithmetic is modulo 2^DW.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd<=simm.
  - 2 ADD: rd<=rd+rs.
  - 3 SUB: rd<=rd-rs.
  - 4 AND, 5 OR, 6 XOR: rd<=rd op rs.
  - 7 MUL: result<=unsigned rd*rs, full 2*DW bits.
  - 8 ADDI: rd<=rd+simm.
  - 9 BEQZ: if rd==0 then pc<=pc+1+sext(imm8) modulo 2^PCW.
  - A JMP: pc<=zero-extended imm8.
  - B OUT: result<=zero-extended rd.
  - F HALT.
  - C/D/E: set illegal and otherwise execute as NOP.
- PC update: non-branch and not-taken instructions set pc<=pc+1, wrapping modulo 2^PCW.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: imem_req=1. On a cycle with imem_valid=1, load IR<=imem_rdata and go to EXEC. Otherwise remain in FETCH with pc and imem_addr held stable.
  - EXEC: perform the register/result/pc update, increment retired, go to FETCH. HALT instead goes to HALT.
  - HALT: imem_req=0, all state frozen, halted=1. Exit only via rst.
- Latency: zero-wait memory gives 2 cycles per instruction. Each cycle imem_valid is delayed adds one cycle.
- result and result_valid:
  - result is written in EXEC by MUL/OUT only.
  - result_valid is registered high for exactly the one cycle following that EXEC.
- Register semantics: reads in EXEC see values before the write. rd==rs is legal (e.g. ADD r0,r0 doubles r0).
- HALT counts as retired, incremented once on entry. Illegal opcodes also count as retired.
- Reset values:
  - State: FETCH.
  - pc, IR, all registers, result, retired: 0.
  - result_valid, halted, illegal: 0.
  - rst overrides every other event in the same cycle, including mid-fetch or mid-exec. An in-flight fetch is abandoned and its imem_valid is ignored.
  - The first fetch after rst deasserts is from address 0.

Test Plan:
- Basic ALU, DW=16 PCW=8, zero-wait. Program 0x1005, 0x1407, 0x2100, 0xB000, 0xF000 → result=0x0000000C, result_valid pulses exactly once, retired=5, halted=1, pc=4.
- Multiply, DW=16. Program 0x10FF, 0x7000, 0xF000 (r0=0xFFFF, MUL r0,r0) → result=0xFFFE0001, illegal=0.
- Branch loop. Program 0x1003, 0x80FF, 0x9001, 0xA001, 0xB000, 0xF000 → result=0, retired=11, final pc=5.
- Wait states. Rerun the basic ALU program with imem_valid asserted 3 cycles after each imem_req → imem_addr stable while waiting, identical result=12, each instruction takes 5 cycles.
- Illegal opcode. Program 0xC000, 0xF000 → illegal=1 from the first EXEC onward, registers unchanged, retired=2, pc=1.
- Reset mid-operation. Assert rst for 1 cycle while in FETCH with r0=5 and result=12 → next cycle pc=0, result=0, retired=0, imem_req=1, imem_addr=0; a stale imem_valid during rst is not loaded into IR.

Source files
------------

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 4-register core with fetch handshake, branches, multiplier, halt and retire counter
module risc_core_mc #(
    parameter int DW  = 16,
    parameter int PCW = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PCW-1:0]  imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [2*DW-1:0] result,
    output logic            result_valid,
    output logic            halted,
    output logic            illegal,
    output logic [31:0]     retired,
    output logic [PCW-1:0]  pc
);
    localparam logic [1:0] S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2;
    localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4;
    localparam logic [3:0] OP_OR = 4'h5, OP_XOR = 4'h6, OP_MUL = 4'h7, OP_ADDI = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9, OP_JMP = 4'hA, OP_OUT = 4'hB, OP_HALT = 4'hF;

    logic [1:0]      state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [15:0]     ir_q;
    logic [DW-1:0]   rf_q [4];
    logic [2*DW-1:0] result_q, result_d;
    logic            result_valid_q, illegal_q;
    logic [31:0]     retired_q;

    logic [3:0]      op;
    logic [1:0]      rd, rs;
    logic [7:0]      imm8;
    logic [DW-1:0]   simm, a, b, wr_d;
    logic            exec, wr_en, res_en, bad_op;

    assign op   = ir_q[15:12];
    assign rd   = ir_q[11:10];
    assign rs   = ir_q[9:8];
    assign imm8 = ir_q[7:0];
    assign simm = DW'($signed(imm8));
    assign a    = rf_q[rd];
    assign b    = rf_q[rs];
    assign exec = state_q == S_EXEC;

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign illegal      = illegal_q;
    assign retired      = retired_q;

    // ALU: register write value, result write value and their enables
    always_comb begin
        wr_d = op == OP_LDI ? simm :
               op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b : a + simm;
        wr_en    = exec && (op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI});
        res_en   = exec && (op == OP_MUL || op == OP_OUT);
        result_d = op == OP_MUL ? (2*DW)'(a) * (2*DW)'(b) : (2*DW)'(a);
        bad_op   = op inside {4'hC, 4'hD, 4'hE};
    end

    // next PC: taken BEQZ is relative to pc+1, JMP is absolute, HALT keeps pc
    always_comb begin
        pc_d = (op == OP_BEQZ && a == '0) ? pc_q + PCW'(1) + PCW'($signed(imm8)) :
               op == OP_JMP  ? PCW'(imm8) :
               op == OP_HALT ? pc_q : pc_q + PCW'(1);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // FSM next state: fetch waits for valid, HALT is only left through reset
    always_comb begin
        state_d = state_q == S_FETCH ? (imem_valid ? S_EXEC : S_FETCH) :
                  state_q == S_EXEC  ? (op == OP_HALT ? S_HALT : S_FETCH) : S_HALT;
    end

    // FSM outputs: request suppressed during reset so a stale handshake cannot start
    always_comb begin
        imem_req = state_q == S_FETCH && !rst;
        halted   = state_q == S_HALT;
    end

    // datapath registers: IR capture on handshake, architectural update in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= '0;
            ir_q           <= '0;
            rf_q           <= '{default: '0};
            result_q       <= '0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            retired_q      <= '0;
        end else begin
            if (state_q == S_FETCH && imem_valid) ir_q <= imem_rdata;
            if (exec) pc_q <= pc_d;
            if (exec) retired_q <= retired_q + 32'd1;
            if (wr_en) rf_q[rd] <= wr_d;
            if (res_en) result_q <= result_d;
            result_valid_q <= res_en;
            illegal_q      <= illegal_q | (exec && bad_op);
        end
    end
endmodule

// File: tb/tb_risc_core_mc.sv
// tb_risc_core_mc: directed program table plus reset and illegal-opcode sequences for risc_core_mc
module tb_risc_core_mc;
    logic        clk, rst, imem_req, imem_valid, result_valid, halted, illegal;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rdata;
    logic [31:0] result, retired;

    int checks = 0, errors = 0, rv_cnt = 0, wt = 0, wcnt = 0, cyc;
    logic force_valid = 1'b0, prev_wait = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    logic [15:0] mem [256];

    typedef struct packed {
        int          base;
        int          len;
        int          wt;
        logic [31:0] res;
        int          rv;
        logic [31:0] ret;
        logic [7:0]  pcx;
        logic        ill;
        int          cyc;
    } vec_t;
    vec_t vec [8];

    logic [15:0] rom [33] = '{
        16'h1005, 16'h1407, 16'h2100, 16'hB000, 16'hF000,
        16'h10FF, 16'h7000, 16'hF000,
        16'h1003, 16'h80FF, 16'h9001, 16'hA001, 16'hB000, 16'hF000,
        16'hC000, 16'hF000,
        16'h100C, 16'h140A, 16'h180C, 16'h6900, 16'h5100, 16'h3200, 16'h4100, 16'h2000, 16'hB000, 16'hF000,
        16'h1CFF, 16'hBC00, 16'h8C01, 16'h9C01, 16'h1C05, 16'hBC00, 16'hF000};

    risc_core_mc #(.DW(16), .PCW(8)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .result(result),
        .result_valid(result_valid), .halted(halted), .illegal(illegal),
        .retired(retired), .pc(pc));

    assign imem_rdata = mem[imem_addr];
    assign imem_valid = force_valid | (imem_req && wcnt >= wt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rst) prev_wait = 1'b0;
        else begin
            if (result_valid) rv_cnt++;
            if (prev_wait && imem_req) chk("addr_stable", 32'(imem_addr), 32'(prev_addr));
            prev_wait = imem_req && !imem_valid;
            prev_addr = imem_addr;
        end
    end

    task automatic load_prog(input int base, input int len);
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        for (int k = 0; k < len; k++) mem[k] = rom[base + k];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        force_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_low", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rv_cnt = 0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_flags", {29'd0, result_valid, halted, illegal}, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", 32'(imem_addr), 32'd0);
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (!halted && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        vec[0] = '{0, 5, 0, 32'h0000000C, 1, 32'd5, 8'd4, 1'b0, 10};
        vec[1] = '{5, 3, 0, 32'hFFFE0001, 1, 32'd3, 8'd2, 1'b0, 6};
        vec[2] = '{8, 6, 0, 32'h00000000, 1, 32'd11, 8'd5, 1'b0, 22};
        vec[3] = '{14, 2, 0, 32'h00000000, 0, 32'd2, 8'd1, 1'b1, 4};
        vec[4] = '{16, 10, 0, 32'h00000010, 1, 32'd10, 8'd9, 1'b0, 20};
        vec[5] = '{26, 7, 0, 32'h00000000, 2, 32'd6, 8'd6, 1'b0, 12};
        vec[6] = '{0, 5, 3, 32'h0000000C, 1, 32'd5, 8'd4, 1'b0, 25};
        vec[7] = '{8, 6, 1, 32'h00000000, 1, 32'd11, 8'd5, 1'b0, 33};
        for (int i = 0; i < 8; i++) begin
            load_prog(vec[i].base, vec[i].len);
            wt = vec[i].wt;
            do_reset();
            run_to_halt(cyc);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vec[i].cyc));
            chk($sformatf("v%0d_result", i), result, vec[i].res);
            chk($sformatf("v%0d_rv_pulses", i), 32'(rv_cnt), 32'(vec[i].rv));
            chk($sformatf("v%0d_retired", i), retired, vec[i].ret);
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vec[i].pcx));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vec[i].ill));
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_frozen_halted", i), 32'(halted), 32'd1);
            chk($sformatf("v%0d_frozen_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("v%0d_frozen_pc", i), 32'(pc), 32'(vec[i].pcx));
            chk($sformatf("v%0d_frozen_retired", i), retired, vec[i].ret);
        end

        load_prog(14, 2);
        wt = 0;
        do_reset();
        @(negedge clk);
        chk("ill_before_exec", 32'(illegal), 32'd0);
        @(negedge clk);
        chk("ill_first_exec", 32'(illegal), 32'd1);
        chk("ill_first_retired", retired, 32'd1);
        chk("ill_first_pc", 32'(pc), 32'd1);

        load_prog(0, 5);
        wt = 3;
        do_reset();
        cyc = 0;
        while (retired != 32'd4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_pre_result", result, 32'h0000000C);
        chk("mid_pre_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        force_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_retired", retired, 32'd0);
        rst = 1'b0;
        force_valid = 1'b0;
        rv_cnt = 0;
        #1;
        chk("mid_post_req", 32'(imem_req), 32'd1);
        chk("mid_post_addr", 32'(imem_addr), 32'd0);
        run_to_halt(cyc);
        chk("mid_rerun_cycles", 32'(cyc), 32'd25);
        chk("mid_rerun_result", result, 32'h0000000C);
        chk("mid_rerun_retired", retired, 32'd5);
        chk("mid_rerun_rv", 32'(rv_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
